// File: rtl/wb_counter_pkg.sv
// Register map, control-bit positions and ID constant shared by the wb_counter_bank files.
package wb_counter_pkg;

  localparam int unsigned WORD_W = 3;
  localparam int unsigned CTRL_W = 4;

  localparam logic [WORD_W-1:0] W_CTRL    = 3'd0;
  localparam logic [WORD_W-1:0] W_COUNT   = 3'd1;
  localparam logic [WORD_W-1:0] W_COMPARE = 3'd2;
  localparam logic [WORD_W-1:0] W_LOAD    = 3'd3;
  localparam logic [WORD_W-1:0] W_STATUS  = 3'd4;

  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_DOWN       = 1;
  localparam int unsigned CTRL_AUTORELOAD = 2;
  localparam int unsigned CTRL_IRQ_EN     = 3;

  localparam logic [8:0] ADDR_ID       = 9'h100;
  localparam logic [8:0] ADDR_PRESCALE = 9'h104;

  localparam logic [31:0] ID_DEFAULT = 32'h434E_5442;

  // Byte-lane write merge: lanes with sel set take the new data.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: CTRL/COUNT/COMPARE/LOAD/STATUS registers, count and match logic,
// and the match toggle output.
module counter_channel
  import wb_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] word,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_sel,
  output logic [31:0]       rd_data_c,
  output logic              irq_req_c,
  output logic              match_tgl_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  compare_q, compare_d;
  logic [WIDTH-1:0]  load_q, load_d;
  logic              status_q, status_d;
  logic              tgl_q, tgl_d;

  logic              match_c;
  logic [WIDTH-1:0]  step_c;

  // Mode bits come from the post-write CTRL so an en clear stops counting on the same edge.
  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    load_d    = load_q;
    status_d  = status_q;
    tgl_d     = tgl_q;
    match_c   = 1'b0;

    if (wr_en && word == W_CTRL)
      ctrl_d = CTRL_W'(byte_merge(32'(ctrl_q), wr_data, wr_sel));
    if (wr_en && word == W_COMPARE)
      compare_d = WIDTH'(byte_merge(32'(compare_q), wr_data, wr_sel));
    if (wr_en && word == W_LOAD)
      load_d = WIDTH'(byte_merge(32'(load_q), wr_data, wr_sel));

    step_c = ctrl_d[CTRL_DOWN] ? count_q - WIDTH'(1) : count_q + WIDTH'(1);

    if (wr_en && word == W_COUNT) begin
      count_d = WIDTH'(byte_merge(32'(count_q), wr_data, wr_sel));
    end else if (tick && ctrl_d[CTRL_EN]) begin
      if (count_q == compare_q) begin
        match_c = 1'b1;
        count_d = ctrl_d[CTRL_AUTORELOAD] ? load_q : step_c;
      end else begin
        count_d = step_c;
      end
    end

    // A fresh match wins over a simultaneous write-1-to-clear.
    if (wr_en && word == W_STATUS && wr_sel[0] && wr_data[0])
      status_d = 1'b0;
    if (match_c) begin
      status_d = 1'b1;
      tgl_d    = ~tgl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      load_q    <= '0;
      status_q  <= 1'b0;
      tgl_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      load_q    <= load_d;
      status_q  <= status_d;
      tgl_q     <= tgl_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    case (word)
      W_CTRL:    rd_data_c = 32'(ctrl_q);
      W_COUNT:   rd_data_c = 32'(count_q);
      W_COMPARE: rd_data_c = 32'(compare_q);
      W_LOAD:    rd_data_c = 32'(load_q);
      W_STATUS:  rd_data_c = 32'(status_q);
      default:   rd_data_c = '0;
    endcase
  end

  assign irq_req_c   = status_q & ctrl_q[CTRL_IRQ_EN];
  assign match_tgl_o = tgl_q;

endmodule

// File: rtl/wb_counter_bank.sv
// Wishbone bank of NCH counters: bus decode, single-cycle ack, read mux, shared prescaler, IRQ.
// Define COUNTER_PRESCALER_EN to add the PRESCALE register at 0x104 and the tick divider.
module wb_counter_bank
  import wb_counter_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned WIDTH    = 16,
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic           wb_clk_i,
  input  logic           rst_n,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic [NCH-1:0] match_tgl_o,
  output logic           irq_o
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              irq_q, irq_d;
  logic              valid_c, wr_c, tick_c;
  logic [2:0]        ch_c;
  logic [WORD_W-1:0] word_c;
  logic [8:0]        gaddr_c;
  logic [31:0]       rdata_c, prescale_rd_c;
  logic [NCH-1:0]    irq_req_c;
  logic [31:0]       ch_rdata_c [NCH];
  logic              unused_adr;

  assign valid_c    = wbs_cyc_i & wbs_stb_i;
  assign ack_d      = valid_c & ~ack_q;
  assign wr_c       = ack_d & wbs_we_i;
  assign ch_c       = wbs_adr_i[7:5];
  assign word_c     = wbs_adr_i[4:2];
  assign gaddr_c    = {wbs_adr_i[8:2], 2'b00};
  assign unused_adr = ^{wbs_adr_i[31:9], wbs_adr_i[1:0]};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    counter_channel #(.WIDTH(WIDTH)) u_ch (
      .clk         (wb_clk_i),
      .rst_n       (rst_n),
      .tick        (tick_c),
      .wr_en       (wr_c && !wbs_adr_i[8] && (ch_c == 3'(i))),
      .word        (word_c),
      .wr_data     (wbs_dat_i),
      .wr_sel      (wbs_sel_i),
      .rd_data_c   (ch_rdata_c[i]),
      .irq_req_c   (irq_req_c[i]),
      .match_tgl_o (match_tgl_o[i])
    );
  end

`ifdef COUNTER_PRESCALER_EN
  localparam int unsigned PRESCALE_W = 16;

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic                  wr_pre_c;

  assign wr_pre_c      = wr_c && (gaddr_c == ADDR_PRESCALE);
  assign tick_c        = (pc_q == prescale_q);
  assign prescale_rd_c = 32'(prescale_q);

  // Shared divider; a PRESCALE write restarts the period.
  always_comb begin
    prescale_d = prescale_q;
    pc_d       = tick_c ? '0 : pc_q + PRESCALE_W'(1);
    if (wr_pre_c) begin
      prescale_d = PRESCALE_W'(byte_merge(32'(prescale_q), wbs_dat_i, wbs_sel_i));
      pc_d       = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      pc_q       <= '0;
    end else begin
      prescale_q <= prescale_d;
      pc_q       <= pc_d;
    end
  end
`else
  assign tick_c        = 1'b1;
  assign prescale_rd_c = '0;
`endif

  always_comb begin
    rdata_c = '0;
    if (!wbs_adr_i[8]) begin
      for (int j = 0; j < NCH; j++) begin
        if (ch_c == 3'(j)) rdata_c = ch_rdata_c[j];
      end
    end else if (gaddr_c == ADDR_ID) begin
      rdata_c = ID_VALUE;
    end else if (gaddr_c == ADDR_PRESCALE) begin
      rdata_c = prescale_rd_c;
    end
  end

  assign dat_d = ack_d ? rdata_c : dat_q;
  assign irq_d = |irq_req_c;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      irq_q <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule
